gate_truth_checker: RTL

Synthesizable truth-table sweeper and checker for a two-input, one-output combinational gate (and_gate and siblings). It drives the gate inputs through all four vectors, holds each for a programmable dwell, and samples the gate output at the end of each dwell. It then compares the observed table against an expected table and reports pass/fail. It is the hardware counterpart of the bench stimulus/monitor loop and runs on-chip or in self-checking regressions.

---
 rtl/gate_check_pkg.sv | 24 ++
 rtl/gate_dwell_timer.sv | 40 ++++
 rtl/gate_truth_checker.sv | 133 +++++++++++++
 3 files changed

// File: rtl/gate_check_pkg.sv
// gate_check_pkg
// Shared types and constants for the gate truth-table checker.
//   state_t        : sweep controller states (IDLE, RUN, REPORT)
//   VEC_W          : width of the stimulus vector index ({a,b})
//   CNT_W          : width of the dwell counter (DWELL up to 255)
//   TT_*           : truth tables of common two-input gates,
//                    bit index = {a,b}
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int VEC_W = 2;
    localparam int CNT_W = 8;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_dwell_timer.sv
// gate_dwell_timer
// Modulo-DWELL counter that paces how long each stimulus vector is held.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   clear  : forces the count back to zero (used while not sweeping)
//   enable : advance the count this cycle
//   tc     : high during the last cycle of each dwell window
module gate_dwell_timer
    import gate_check_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] count;

    // The count wraps to zero on its own terminal cycle so consecutive
    // vectors each get exactly DWELL cycles without a separate reload.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            if (tc) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign tc = enable && (count == LAST);

endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker
// Sweeps a two-input gate through 00,01,10,11, holds each vector for DWELL
// cycles, samples the gate output in the last dwell cycle, and compares
// the observed truth table against EXPECTED.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   start      : begin a sweep (only honoured in IDLE)
//   drv_a/b    : registered stimulus to the gate inputs
//   resp       : gate output (combinational from drv_a/drv_b)
//   busy       : high from the first drive cycle through REPORT
//   done       : one-cycle pulse in REPORT
//   pass       : observed table equals EXPECTED, held until next done
//   table_o    : observed table of the last sweep, bit index = {a,b}
//   mismatch_o : table_o XOR EXPECTED
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int         DWELL    = 2,
    parameter logic [3:0] EXPECTED = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       drv_a,
    output logic       drv_b,
    input  logic       resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] table_o,
    output logic [3:0] mismatch_o
);

    state_t           state, state_nxt;
    logic [VEC_W-1:0] vec, vec_nxt;
    logic [3:0]       obs, obs_nxt;
    logic [1:0]       drv_nxt;
    logic             busy_nxt, done_nxt, pass_nxt;
    logic [3:0]       table_nxt, mismatch_nxt;
    logic             tc;

    // The timer only runs in RUN; holding it cleared elsewhere guarantees
    // every sweep begins with a full dwell on vector 00.
    gate_dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != RUN),
        .enable (state == RUN),
        .tc     (tc)
    );

    // State, working table and every output are registered together, so
    // the outputs change exactly on the edge that changes state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= '0;
            obs        <= '0;
            drv_a      <= 1'b0;
            drv_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            table_o    <= '0;
            mismatch_o <= '0;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            obs        <= obs_nxt;
            drv_a      <= drv_nxt[1];
            drv_b      <= drv_nxt[0];
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            table_o    <= table_nxt;
            mismatch_o <= mismatch_nxt;
        end
    end

    // Next-state logic. The drive value computed here is what the gate
    // sees next cycle, so when a dwell ends we already present vec+1.
    // The final capture is folded straight into table_o so the result is
    // valid in the same cycle that done is high.
    always_comb begin
        state_nxt    = state;
        vec_nxt      = vec;
        obs_nxt      = obs;
        drv_nxt      = 2'b00;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        pass_nxt     = pass;
        table_nxt    = table_o;
        mismatch_nxt = mismatch_o;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    vec_nxt   = '0;
                    obs_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                busy_nxt = 1'b1;
                drv_nxt  = vec;
                if (tc) begin
                    obs_nxt[vec] = resp;
                    if (vec == VEC_W'(3)) begin
                        state_nxt    = REPORT;
                        drv_nxt      = 2'b00;
                        done_nxt     = 1'b1;
                        table_nxt    = obs_nxt;
                        mismatch_nxt = obs_nxt ^ EXPECTED;
                        pass_nxt     = (obs_nxt == EXPECTED);
                    end else begin
                        vec_nxt = vec + VEC_W'(1);
                        drv_nxt = vec + VEC_W'(1);
                    end
                end
            end
            REPORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
